// File: rtl/mul_iter_sequencer_if.sv
// Bundle between the EX stage and the iterative multiplier.
// Handshake: the pipeline raises mul_start while a MUL sits in EX and keeps it
// high for as long as stall is high. stall freezes IF/ID/EX. done is a single-cycle
// pulse with stall low, so the pipeline advances and captures product on that edge.
// flush kills the request or the operation in flight. dbg_state exposes the FSM.
interface mul_iter_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             mul_start;
    logic             flush;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic [1:0]       dbg_state;

    modport master (
        output mul_start, flush, op_a, op_b,
        input  stall, busy, done, product, dbg_state
    );

    modport slave (
        input  mul_start, flush, op_a, op_b,
        output stall, busy, done, product, dbg_state
    );
endinterface

// File: rtl/mul_iter_sequencer.sv
// Iterative radix-2 shift-add multiplier for MUL in EX. It stalls the front of
// the pipeline while it computes and presents the low WIDTH product bits for
// one cycle.
module mul_iter_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           reset,
    mul_iter_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_product;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;
    logic             w_start;

    // Datapath step and control decodes. The final step is taken when no
    // multiplier bits remain above the current one, or on the last bit position.
    always_comb begin
        w_acc_next = r_acc;
        if (r_mplier[0]) begin
            w_acc_next = r_acc + r_mcand;
        end
        w_last  = (r_mplier[WIDTH-1:1] == '0) || (r_cnt == CNT_W'(WIDTH - 1));
        w_start = bus.mul_start & ~bus.flush;
    end

    // Control FSM and datapath registers. Reset overrides everything. In RUN,
    // flush wins over the multiply step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_start) begin
                        r_acc    <= '0;
                        r_mcand  <= bus.op_a;
                        r_mplier <= bus.op_b;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_product <= w_acc_next;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // The same MUL is still in EX here, so mul_start and flush are ignored.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // stall is asserted in the cycle the request is first seen, so the MUL stays in EX.
    assign bus.stall     = ~reset & (((r_state == S_IDLE) & w_start) | (r_state == S_RUN));
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.product   = r_product;
    assign bus.dbg_state = r_state;

endmodule
